// File: rtl/strike_tracker.sv
// Per-channel strike counters with lockout threshold, global saturating total and lowest-locked-slot encoder.
// All state registered, one-cycle latency; no backpressure: strikes on locked or cleared channels are dropped.
module strike_tracker #(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 4,
   parameter int TOT_W     = 8,
   parameter int WRAP_MODE = 0,
   parameter int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [NUM_CH-1:0]       strike_flag,
   input  logic [NUM_CH-1:0]       clear,
   input  logic                    clear_all,
   input  logic [CNT_W-1:0]        threshold,
   output logic [NUM_CH*CNT_W-1:0] count_flat,
   output logic [NUM_CH-1:0]       locked,
   output logic [NUM_CH-1:0]       lock_pulse,
   output logic [NUM_CH-1:0]       ovf,
   output logic [TOT_W-1:0]        total_strikes,
   output logic                    any_locked,
   output logic                    all_locked,
   output logic [IDX_W-1:0]        first_locked_idx
);

   localparam int PC_W  = $clog2(NUM_CH + 1);
   localparam int SUM_W = TOT_W + PC_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [SUM_W-1:0] TOT_MAX = {{PC_W{1'b0}}, {TOT_W{1'b1}}};

   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]            locked_q, locked_d;
   logic [NUM_CH-1:0]            pulse_q, pulse_d;
   logic [NUM_CH-1:0]            ovf_q, ovf_d;
   logic [NUM_CH-1:0]            clr_eff;
   logic [NUM_CH-1:0]            accept;
   logic [TOT_W-1:0]             total_q, total_d;
   logic [PC_W-1:0]              n_acc;
   logic [SUM_W-1:0]             sum;

   assign clr_eff = clear | {NUM_CH{clear_all}};

   always_comb begin
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      locked_d = '0;
      pulse_d  = '0;
      accept   = '0;
      n_acc    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         accept[i] = en & strike_flag[i] & ~clr_eff[i] & ~locked_q[i];
         if (clr_eff[i]) begin
            cnt_d[i] = '0;
            ovf_d[i] = 1'b0;
         end else if (accept[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ovf_d[i] = 1'b1;
               if (WRAP_MODE != 0) cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         // Lock is re-evaluated every cycle so a lowered threshold catches existing counts.
         locked_d[i] = ~clr_eff[i] & (locked_q[i] | ((threshold != '0) && (cnt_d[i] >= threshold)));
         pulse_d[i]  = locked_d[i] & ~locked_q[i];
         n_acc       = n_acc + PC_W'(accept[i]);
      end
      sum = SUM_W'(total_q) + SUM_W'(n_acc);
      if (clear_all)
         total_d = '0;
      else if (sum > TOT_MAX)
         total_d = '1;
      else
         total_d = TOT_W'(sum);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         locked_q <= '0;
         pulse_q  <= '0;
         ovf_q    <= '0;
         total_q  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
         pulse_q  <= pulse_d;
         ovf_q    <= ovf_d;
         total_q  <= total_d;
      end
   end

   always_comb begin
      first_locked_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (locked_q[i]) first_locked_idx = IDX_W'(i);
      end
   end

   assign count_flat    = cnt_q;
   assign locked        = locked_q;
   assign lock_pulse    = pulse_q;
   assign ovf           = ovf_q;
   assign total_strikes = total_q;
   assign any_locked    = |locked_q;
   assign all_locked    = &locked_q;

endmodule

// File: tb/tb_strike_tracker.sv
// Directed bench: default, wrapping and narrow-total variants driven from shared inputs.
module tb_strike_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [3:0] strike_flag = '0;
   logic [3:0] clear = '0;
   logic       clear_all = 1'b0;
   logic [3:0] threshold = '0;

   logic [15:0] cnt0, cnt1, cnt2;
   logic [3:0]  lck0, lck1, lck2, pls0, pls1, pls2, ovf0, ovf1, ovf2;
   logic [7:0]  tot0, tot1;
   logic [3:0]  tot2;
   logic        any0, any1, any2, all0, all1, all2;
   logic [1:0]  idx0, idx1, idx2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   strike_tracker #(.NUM_CH(4), .CNT_W(4), .TOT_W(8), .WRAP_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .strike_flag(strike_flag), .clear(clear),
      .clear_all(clear_all), .threshold(threshold), .count_flat(cnt0), .locked(lck0),
      .lock_pulse(pls0), .ovf(ovf0), .total_strikes(tot0), .any_locked(any0),
      .all_locked(all0), .first_locked_idx(idx0));

   strike_tracker #(.NUM_CH(4), .CNT_W(4), .TOT_W(8), .WRAP_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .strike_flag(strike_flag), .clear(clear),
      .clear_all(clear_all), .threshold(threshold), .count_flat(cnt1), .locked(lck1),
      .lock_pulse(pls1), .ovf(ovf1), .total_strikes(tot1), .any_locked(any1),
      .all_locked(all1), .first_locked_idx(idx1));

   strike_tracker #(.NUM_CH(4), .CNT_W(4), .TOT_W(4), .WRAP_MODE(0)) dut2 (
      .clk(clk), .rst(rst), .en(en), .strike_flag(strike_flag), .clear(clear),
      .clear_all(clear_all), .threshold(threshold), .count_flat(cnt2), .locked(lck2),
      .lock_pulse(pls2), .ovf(ovf2), .total_strikes(tot2), .any_locked(any2),
      .all_locked(all2), .first_locked_idx(idx2));

   typedef struct {
      logic        en;
      logic [3:0]  sf;
      logic [3:0]  clr;
      logic        ca;
      logic [3:0]  thr;
      logic [15:0] cnt;
      logic [3:0]  lck;
      logic [3:0]  pls;
      logic [3:0]  ovf;
      logic [7:0]  tot;
      logic        any;
      logic        all;
      logic [1:0]  idx;
   } vec_t;

   vec_t vt[17];

   function automatic vec_t mk(input logic e, input logic [3:0] s, input logic [3:0] c,
                               input logic ca, input logic [3:0] t, input logic [15:0] cn,
                               input logic [3:0] l, input logic [3:0] p, input logic [3:0] o,
                               input logic [7:0] to, input logic an, input logic al,
                               input logic [1:0] ix);
      vec_t v;
      v.en = e; v.sf = s; v.clr = c; v.ca = ca; v.thr = t; v.cnt = cn; v.lck = l;
      v.pls = p; v.ovf = o; v.tot = to; v.any = an; v.all = al; v.idx = ix;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [3:0] s, input logic [3:0] c,
                        input logic ca, input logic [3:0] t);
      en = e; strike_flag = s; clear = c; clear_all = ca; threshold = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //          en  sf       clr      ca  thr   cnt       lck      pls      ovf   tot  any all idx
      vt[0]  = mk(1, 4'b0001, 4'b0000, 0, 4'd3,  16'h0001, 4'b0000, 4'b0000, 4'h0, 8'd1,  0, 0, 2'd0);
      vt[1]  = mk(1, 4'b0001, 4'b0000, 0, 4'd3,  16'h0002, 4'b0000, 4'b0000, 4'h0, 8'd2,  0, 0, 2'd0);
      vt[2]  = mk(1, 4'b0001, 4'b0000, 0, 4'd3,  16'h0003, 4'b0001, 4'b0001, 4'h0, 8'd3,  1, 0, 2'd0);
      vt[3]  = mk(1, 4'b1111, 4'b0000, 0, 4'd3,  16'h1113, 4'b0001, 4'b0000, 4'h0, 8'd6,  1, 0, 2'd0);
      vt[4]  = mk(1, 4'b0010, 4'b0010, 0, 4'd3,  16'h1103, 4'b0001, 4'b0000, 4'h0, 8'd6,  1, 0, 2'd0);
      vt[5]  = mk(0, 4'b1111, 4'b0000, 0, 4'd3,  16'h1103, 4'b0001, 4'b0000, 4'h0, 8'd6,  1, 0, 2'd0);
      vt[6]  = mk(1, 4'b1000, 4'b0000, 0, 4'd0,  16'h2103, 4'b0001, 4'b0000, 4'h0, 8'd7,  1, 0, 2'd0);
      vt[7]  = mk(1, 4'b1000, 4'b0000, 0, 4'd0,  16'h3103, 4'b0001, 4'b0000, 4'h0, 8'd8,  1, 0, 2'd0);
      vt[8]  = mk(1, 4'b1000, 4'b0000, 0, 4'd0,  16'h4103, 4'b0001, 4'b0000, 4'h0, 8'd9,  1, 0, 2'd0);
      vt[9]  = mk(1, 4'b1000, 4'b0000, 0, 4'd0,  16'h5103, 4'b0001, 4'b0000, 4'h0, 8'd10, 1, 0, 2'd0);
      vt[10] = mk(1, 4'b0000, 4'b0000, 0, 4'd4,  16'h5103, 4'b1001, 4'b1000, 4'h0, 8'd10, 1, 0, 2'd0);
      vt[11] = mk(1, 4'b0000, 4'b0000, 0, 4'd15, 16'h5103, 4'b1001, 4'b0000, 4'h0, 8'd10, 1, 0, 2'd0);
      vt[12] = mk(1, 4'b1000, 4'b0000, 0, 4'd15, 16'h5103, 4'b1001, 4'b0000, 4'h0, 8'd10, 1, 0, 2'd0);
      vt[13] = mk(1, 4'b0000, 4'b0001, 0, 4'd15, 16'h5100, 4'b1000, 4'b0000, 4'h0, 8'd10, 1, 0, 2'd3);
      vt[14] = mk(1, 4'b1111, 4'b0000, 1, 4'd15, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'd0,  0, 0, 2'd0);
      vt[15] = mk(1, 4'b1111, 4'b0000, 0, 4'd1,  16'h1111, 4'b1111, 4'b1111, 4'h0, 8'd4,  1, 1, 2'd0);
      vt[16] = mk(1, 4'b0000, 4'b0000, 0, 4'd1,  16'h1111, 4'b1111, 4'b0000, 4'h0, 8'd4,  1, 1, 2'd0);

      // Reset state while held in reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst cnt", 32'(cnt0), 0);
      chk("rst lck", 32'(lck0), 0);
      chk("rst pls", 32'(pls0), 0);
      chk("rst ovf", 32'(ovf0), 0);
      chk("rst tot", 32'(tot0), 0);
      chk("rst any", 32'(any0), 0);
      chk("rst idx", 32'(idx0), 0);
      @(negedge clk) rst = 1'b1;

      // Asynchronous reset mid-run with nonzero counts
      drive(1, 4'b0011, 4'b0000, 0, 4'd3);
      drive(1, 4'b0011, 4'b0000, 0, 4'd3);
      chk("pre-arst cnt", 32'(cnt0), 32'h0022);
      chk("pre-arst tot", 32'(tot0), 4);
      #2 rst = 1'b0;
      #1;
      chk("arst cnt", 32'(cnt0), 0);
      chk("arst tot", 32'(tot0), 0);
      en = 1'b0; strike_flag = '0;
      @(negedge clk) rst = 1'b1;

      for (int k = 0; k < 17; k++) begin
         drive(vt[k].en, vt[k].sf, vt[k].clr, vt[k].ca, vt[k].thr);
         chk($sformatf("v%0d cnt", k), 32'(cnt0), 32'(vt[k].cnt));
         chk($sformatf("v%0d lck", k), 32'(lck0), 32'(vt[k].lck));
         chk($sformatf("v%0d pls", k), 32'(pls0), 32'(vt[k].pls));
         chk($sformatf("v%0d ovf", k), 32'(ovf0), 32'(vt[k].ovf));
         chk($sformatf("v%0d tot", k), 32'(tot0), 32'(vt[k].tot));
         chk($sformatf("v%0d any", k), 32'(any0), 32'(vt[k].any));
         chk($sformatf("v%0d all", k), 32'(all0), 32'(vt[k].all));
         chk($sformatf("v%0d idx", k), 32'(idx0), 32'(vt[k].idx));
      end

      // Saturate (dut0) versus wrap (dut1) on channel 2
      drive(0, 4'b0000, 4'b0000, 1, 4'd0);
      for (int k = 0; k < 15; k++) drive(1, 4'b0100, 4'b0000, 0, 4'd0);
      chk("sat15 cnt", 32'(cnt0), 32'h0F00);
      chk("sat15 ovf", 32'(ovf0), 0);
      chk("wrap15 cnt", 32'(cnt1), 32'h0F00);
      chk("wrap15 ovf", 32'(ovf1), 0);
      drive(1, 4'b0100, 4'b0000, 0, 4'd0);
      chk("sat16 cnt", 32'(cnt0), 32'h0F00);
      chk("sat16 ovf", 32'(ovf0), 32'h4);
      chk("wrap16 cnt", 32'(cnt1), 32'h0000);
      chk("wrap16 ovf", 32'(ovf1), 32'h4);
      drive(1, 4'b0100, 4'b0000, 0, 4'd0);
      chk("sat17 cnt", 32'(cnt0), 32'h0F00);
      chk("sat17 tot", 32'(tot0), 17);
      chk("wrap17 cnt", 32'(cnt1), 32'h0100);
      chk("wrap17 ovf", 32'(ovf1), 32'h4);
      chk("wrap17 tot", 32'(tot1), 17);
      chk("wrap lck", 32'(lck1), 0);
      chk("wrap pls", 32'(pls1), 0);
      chk("wrap any", 32'(any1), 0);
      chk("wrap all", 32'(all1), 0);
      chk("wrap idx", 32'(idx1), 0);

      // Narrow total saturates and holds; en=0 freezes counts
      drive(0, 4'b0000, 4'b0000, 1, 4'd0);
      chk("tsat clr", 32'(tot2), 0);
      for (int k = 1; k <= 4; k++) begin
         drive(1, 4'b1111, 4'b0000, 0, 4'd0);
         chk($sformatf("tsat step%0d", k), 32'(tot2), (4 * k > 15) ? 15 : 4 * k);
      end
      drive(1, 4'b1111, 4'b0000, 0, 4'd0);
      chk("tsat hold", 32'(tot2), 15);
      chk("tsat cnt", 32'(cnt2), 32'h5555);
      drive(0, 4'b1111, 4'b0000, 0, 4'd0);
      chk("en0 cnt", 32'(cnt2), 32'h5555);
      chk("en0 tot", 32'(tot2), 15);
      chk("tsat lck", 32'(lck2), 0);
      chk("tsat pls", 32'(pls2), 0);
      chk("tsat ovf", 32'(ovf2), 0);
      chk("tsat any", 32'(any2), 0);
      chk("tsat all", 32'(all2), 0);
      chk("tsat idx", 32'(idx2), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
